// File: rtl/tc_timer.sv
// tc_timer: memory-mapped timer/counter on the CPU device bridge.
// Mode 0 counts down once and holds its interrupt until CTRL is rewritten.
// Mode 1 auto-reloads and gives a 1-cycle interrupt pulse every PRESET+3 cycles.
module tc_timer #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    Addr,
   input  logic          We,
   input  logic [DW-1:0] Din,
   output logic [DW-1:0] Dout,
   output logic          IRQ
);

   // Word offsets on the bridge (address bits [3:2])
   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PRESET = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;

   localparam logic [DW-1:0] ONE = DW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [3:0]    ctrl;
   logic [DW-1:0] preset;
   logic [DW-1:0] count;
   logic          irq_flag;

   // CTRL fields
   logic enable, mask_ok, mode1;
   assign enable  = ctrl[0];
   assign mode1   = (ctrl[2:1] == 2'b01);   // 1x falls back to one-shot
   assign mask_ok = ctrl[3];

   // Bus write strobes
   logic wr_ctrl, wr_preset;
   assign wr_ctrl   = We && (Addr == A_CTRL);
   assign wr_preset = We && (Addr == A_PRESET);

   // Datapath actions requested by the FSM this cycle
   logic do_load, do_dec, do_expire, do_irq_clr, do_en_clr;

   // Next-state and datapath control
   always_comb begin
      state_nx   = state;
      do_load    = 1'b0;
      do_dec     = 1'b0;
      do_expire  = 1'b0;
      do_irq_clr = 1'b0;
      do_en_clr  = 1'b0;
      case (state)
         IDLE: if (enable) state_nx = LOAD;
         LOAD: begin
            do_load  = 1'b1;
            state_nx = CNT;
         end
         CNT: begin
            if (!enable) begin
               // count freezes; re-enabling goes through LOAD again
               state_nx = IDLE;
            end else if (count <= ONE) begin
               // PRESET=0 lands here too, so it behaves like PRESET=1
               do_expire = 1'b1;
               state_nx  = INT;
            end else begin
               do_dec = 1'b1;
            end
         end
         INT: begin
            if (mode1) do_irq_clr = 1'b1;   // pulse; enable stays set -> reload
            else       do_en_clr  = 1'b1;   // one-shot; flag held until CTRL write
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (reset)          count <= '0;
      else if (do_load)   count <= preset;
      else if (do_expire) count <= '0;
      else if (do_dec)    count <= count - ONE;
   end

   // PRESET register; a new value only takes effect at the next LOAD
   always_ff @(posedge clk) begin
      if (reset)          preset <= '0;
      else if (wr_preset) preset <= Din;
   end

   // CTRL register; a CPU write overrides the one-shot enable clear
   always_ff @(posedge clk) begin
      if (reset)          ctrl <= 4'h0;
      else if (wr_ctrl)   ctrl <= Din[3:0];
      else if (do_en_clr) ctrl[0] <= 1'b0;
   end

   // Interrupt flag; a CTRL write clears it even in the cycle the FSM would set it
   always_ff @(posedge clk) begin
      if (reset)           irq_flag <= 1'b0;
      else if (wr_ctrl)    irq_flag <= 1'b0;
      else if (do_expire)  irq_flag <= 1'b1;
      else if (do_irq_clr) irq_flag <= 1'b0;
   end

   // Combinational read mux
   always_comb begin
      Dout = '0;
      case (Addr)
         A_CTRL:   Dout = {{(DW-4){1'b0}}, ctrl};
         A_PRESET: Dout = preset;
         A_COUNT:  Dout = count;
         default:  Dout = '0;
      endcase
   end

   // Mask only gates the output; the flag survives IM=0
   assign IRQ = irq_flag & mask_ok;

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer: hand-computed COUNT/IRQ/CTRL sequences.
module tb_tc_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  Addr;
   logic        We;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   int n_tests = 0;
   int n_fail  = 0;

   tc_timer #(.DW(32)) dut (
      .clk  (clk),
      .reset(reset),
      .Addr (Addr),
      .We   (We),
      .Din  (Din),
      .Dout (Dout),
      .IRQ  (IRQ)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // advance n edges, ending 1 time unit after the last one
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // single-cycle store; returns 1 unit after the write edge
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      Addr = a; Din = d; We = 1'b1;
      @(posedge clk);
      #1;
      We = 1'b0; Addr = 2'd0; Din = '0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      Addr = a;
      #1;
      v = Dout;
   endtask

   logic [31:0] v;
   logic [31:0] exp_cnt;
   logic        exp_irq;
   int          j;
   logic        saw_irq;

   initial begin
      reset = 1'b1; We = 1'b0; Addr = 2'd0; Din = '0;
      step(3);
      reset = 1'b0;

      // reset state
      rd(2'd0, v); chk("rst_ctrl", v, 32'h0);
      rd(2'd1, v); chk("rst_preset", v, 32'h0);
      rd(2'd2, v); chk("rst_count", v, 32'h0);
      rd(2'd3, v); chk("rst_addr3", v, 32'h0);
      chk("rst_irq", {31'b0, IRQ}, 32'h0);

      // mode 0 one-shot, PRESET=5: IRQ 7 edges after CTRL write
      wr(2'd1, 32'd5);
      rd(2'd1, v); chk("m0_preset", v, 32'd5);
      wr(2'd0, 32'h9);
      for (int k = 1; k <= 10; k++) begin
         step(1);
         exp_cnt = (k < 2) ? 32'd0 : (k <= 7 ? 32'(7 - k) : 32'd0);
         exp_irq = (k >= 7);
         rd(2'd2, v); chk($sformatf("m0_count_k%0d", k), v, exp_cnt);
         chk($sformatf("m0_irq_k%0d", k), {31'b0, IRQ}, {31'b0, exp_irq});
      end
      rd(2'd0, v); chk("m0_ctrl_after", v, 32'h8);
      wr(2'd0, 32'h0);
      chk("m0_irq_cleared", {31'b0, IRQ}, 32'h0);

      // mode 1 periodic, PRESET=5: 1-cycle pulse every 8 cycles
      wr(2'd0, 32'hB);
      for (int k = 1; k <= 26; k++) begin
         step(1);
         exp_irq = (k >= 7) && (((k - 7) % 8) == 0);
         j = (k - 2) % 8;
         exp_cnt = (k >= 2 && j <= 5) ? 32'(5 - j) : 32'd0;
         chk($sformatf("m1_irq_k%0d", k), {31'b0, IRQ}, {31'b0, exp_irq});
         rd(2'd2, v); chk($sformatf("m1_count_k%0d", k), v, exp_cnt);
      end
      rd(2'd0, v); chk("m1_ctrl", v, 32'hB);
      wr(2'd0, 32'h0);
      step(2);

      // masked interrupt, PRESET=3, IM=0
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h1);
      step(5);
      rd(2'd2, v); chk("mask_count0", v, 32'd0);
      chk("mask_irq_low", {31'b0, IRQ}, 32'h0);
      step(2);
      chk("mask_irq_still_low", {31'b0, IRQ}, 32'h0);
      wr(2'd0, 32'h8);
      chk("mask_clear_irq", {31'b0, IRQ}, 32'h0);
      step(3);
      chk("mask_clear_irq2", {31'b0, IRQ}, 32'h0);
      // second run: unmask before expiry
      wr(2'd0, 32'h1);
      step(3);
      rd(2'd2, v); chk("mask2_count", v, 32'd2);
      wr(2'd0, 32'h9);
      rd(2'd2, v); chk("mask2_count_at_wr", v, 32'd1);
      chk("mask2_irq_before", {31'b0, IRQ}, 32'h0);
      step(1);
      chk("mask2_irq_expiry", {31'b0, IRQ}, 32'h1);
      wr(2'd0, 32'h0);
      chk("mask2_irq_clr", {31'b0, IRQ}, 32'h0);
      step(2);

      // PRESET=0 behaves like PRESET=1
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      step(2);
      chk("p0_irq_low", {31'b0, IRQ}, 32'h0);
      step(1);
      chk("p0_irq_high", {31'b0, IRQ}, 32'h1);
      wr(2'd0, 32'h0);
      step(2);

      // CTRL write in the cycle that enters INT wins over the flag set
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h9);
      step(3);
      wr(2'd0, 32'h9);
      chk("race_irq", {31'b0, IRQ}, 32'h0);
      step(1);
      rd(2'd0, v); chk("race_ctrl", v, 32'h8);
      chk("race_irq2", {31'b0, IRQ}, 32'h0);
      step(2);

      // disable mid-count, PRESET=100
      wr(2'd1, 32'd100);
      wr(2'd0, 32'h9);
      step(41);
      rd(2'd2, v); chk("dis_count61", v, 32'd61);
      wr(2'd0, 32'h8);
      rd(2'd2, v); chk("dis_count60", v, 32'd60);
      step(5);
      rd(2'd2, v); chk("dis_frozen", v, 32'd60);
      chk("dis_irq", {31'b0, IRQ}, 32'h0);
      wr(2'd0, 32'h9);
      step(2);
      rd(2'd2, v); chk("reen_count100", v, 32'd100);
      step(3);
      rd(2'd2, v); chk("reen_count97", v, 32'd97);
      wr(2'd1, 32'd7);
      rd(2'd2, v); chk("preset_no_disturb", v, 32'd96);
      step(1);
      wr(2'd0, 32'h8);
      step(1);
      wr(2'd0, 32'h9);
      step(2);
      rd(2'd2, v); chk("new_preset_load", v, 32'd7);
      step(6);
      chk("new_preset_irq_low", {31'b0, IRQ}, 32'h0);
      step(1);
      chk("new_preset_irq_high", {31'b0, IRQ}, 32'h1);
      wr(2'd0, 32'h0);
      step(2);

      // reset mid-count, mode 1, PRESET=10
      wr(2'd1, 32'd10);
      wr(2'd0, 32'hB);
      step(7);
      rd(2'd2, v); chk("rst2_count5", v, 32'd5);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      rd(2'd0, v); chk("rst2_ctrl", v, 32'h0);
      rd(2'd1, v); chk("rst2_preset", v, 32'h0);
      rd(2'd2, v); chk("rst2_count", v, 32'h0);
      chk("rst2_irq", {31'b0, IRQ}, 32'h0);
      saw_irq = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step(1);
         if (IRQ) saw_irq = 1'b1;
      end
      chk("rst2_no_irq", {31'b0, saw_irq}, 32'h0);
      rd(2'd2, v); chk("rst2_count_idle", v, 32'h0);
      wr(2'd2, 32'h1234);
      rd(2'd2, v); chk("count_ro", v, 32'h0);
      wr(2'd3, 32'h55);
      rd(2'd3, v); chk("addr3_zero", v, 32'h0);
      rd(2'd0, v); chk("addr3_no_ctrl", v, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // hard stop in case the sequence above ever stalls
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1);
   end

endmodule
